// File: rtl/lycan_globals.sv
// rtl/lycan_globals.sv - shared Lycan constants and USB data packet layout
package lycan_globals;

  localparam int num_peripherals      = 4;
  localparam int usb_packet_width     = 32;
  localparam int periph_address_width = 3;
  localparam int bytes_per_packet     = 3;

  localparam int pkt_addr_msb    = 31;
  localparam int pkt_addr_lsb    = 29;
  localparam int pkt_config_bit  = 28;
  localparam int pkt_count_msb   = 25;
  localparam int pkt_count_lsb   = 24;
  localparam int pkt_count_width = pkt_count_msb - pkt_count_lsb + 1;

  // data[0] is the first byte accepted and lands in bits [7:0]
  typedef struct packed {
    logic [periph_address_width-1:0]  addr;
    logic                             cfg;
    logic [1:0]                       rsvd;
    logic [pkt_count_width-1:0]       count;
    logic [bytes_per_packet-1:0][7:0] data;
  } usb_data_packet_t;

endpackage

// File: rtl/lycan_rr_arbiter.sv
// rtl/lycan_rr_arbiter.sv - combinational round-robin arbiter, first requester at or after ptr
module lycan_rr_arbiter
  import lycan_globals::*;
#(
  parameter int N  = num_peripherals,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  logic [IW:0]   sum;
  logic [IW-1:0] j;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    sum         = '0;
    j           = '0;
    for (int i = 0; i < N; i++) begin
      // rotate the search so index ptr is examined first, wrapping at N
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      j = sum[IW-1:0];
      if (!grant_valid && req[j]) begin
        grant_valid = 1'b1;
        grant[j]    = 1'b1;
        grant_idx   = j;
      end
    end
  end

endmodule

// File: rtl/lycan_packet_packer.sv
// rtl/lycan_packet_packer.sv - packs up to three bytes from one peripheral into a tagged USB packet
module lycan_packet_packer
  import lycan_globals::*;
#(
  parameter int NUM_PERIPH     = num_peripherals,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PERIPH-1:0][7:0]  in_data,
  input  logic [NUM_PERIPH-1:0]       in_valid,
  output logic [NUM_PERIPH-1:0]       in_ready,
  output logic [usb_packet_width-1:0] out_packet,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int IW = (NUM_PERIPH > 1) ? $clog2(NUM_PERIPH) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, EMIT} packer_state_t;

  packer_state_t                    state, state_next;
  logic [IW-1:0]                    ptr, grant_idx, arb_idx, ptr_next;
  logic [NUM_PERIPH-1:0]            grant_oh, arb_grant;
  logic                             arb_valid, accept, timeout_hit, release_grant;
  logic [pkt_count_width-1:0]       count;
  logic [7:0]                       idle_cnt;
  logic [bytes_per_packet-1:0][7:0] data_bytes;
  usb_data_packet_t                 pkt;

  lycan_rr_arbiter #(.N(NUM_PERIPH), .IW(IW)) u_arb (
    .req        (in_valid),
    .ptr        (ptr),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .grant_valid(arb_valid)
  );

  assign in_ready    = (state == COLLECT) ? grant_oh : '0;
  assign accept      = |(in_valid & in_ready);
  assign timeout_hit = (idle_cnt == 8'(TIMEOUT_CYCLES - 1));
  assign ptr_next    = (grant_idx == IW'(NUM_PERIPH - 1)) ? '0 : grant_idx + IW'(1);

  always_comb begin
    state_next    = state;
    release_grant = 1'b0;
    unique case (state)
      IDLE:    if (arb_valid) state_next = COLLECT;
      COLLECT: begin
        if (accept) begin
          if (count == pkt_count_width'(bytes_per_packet - 1)) state_next = EMIT;
        end else if (timeout_hit) begin
          // a grantee that never delivered a byte forfeits its turn silently
          if (count != '0) begin
            state_next = EMIT;
          end else begin
            state_next    = IDLE;
            release_grant = 1'b1;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          state_next    = IDLE;
          release_grant = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      grant_idx  <= '0;
      grant_oh   <= '0;
      count      <= '0;
      idle_cnt   <= '0;
      data_bytes <= '0;
    end else begin
      state <= state_next;
      if (release_grant) ptr <= ptr_next;
      if (state == IDLE && arb_valid) begin
        grant_idx  <= arb_idx;
        grant_oh   <= arb_grant;
        count      <= '0;
        idle_cnt   <= '0;
        data_bytes <= '0;
      end else if (state == COLLECT) begin
        if (accept) begin
          data_bytes[count] <= in_data[grant_idx];
          count             <= count + pkt_count_width'(1);
          idle_cnt          <= '0;
        end else begin
          idle_cnt <= idle_cnt + 8'd1;
        end
      end
    end
  end

  always_comb begin
    pkt       = '0;
    pkt.addr  = periph_address_width'(grant_idx);
    pkt.count = count;
    pkt.data  = data_bytes;
  end

  assign out_valid  = (state == EMIT);
  assign out_packet = out_valid ? pkt : '0;

endmodule

// File: tb/tb_lycan_packet_packer.sv
// tb/tb_lycan_packet_packer.sv - self-checking bench for lycan_packet_packer
`timescale 1ns/1ps
module tb_lycan_packet_packer;

  localparam int NP = 4;
  localparam int TO = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NP-1:0][7:0]   in_data = '0;
  logic [NP-1:0]        in_valid = '0;
  logic [NP-1:0]        in_ready;
  logic [31:0]          out_packet;
  logic                 out_valid;
  logic                 out_ready = 1'b0;

  lycan_packet_packer #(.NUM_PERIPH(NP), .TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_packet(out_packet),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pkt_cnt = 0;
  int last_rise = -1;

  logic          rst_req  = 1'b1;
  logic          ordy_req = 1'b0;
  logic [NP-1:0] en       = '0;
  logic [NP-1:0] hs_prev  = '0;
  logic [7:0]    src_mem [NP][8];
  int            src_len [NP];
  int            src_pos [NP];
  logic [7:0]    acc_mem [NP][64];
  int            acc_wr  [NP];
  int            acc_rd  [NP];
  logic [31:0]   exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_pkt(input int addr, input int n,
                                         input logic [7:0] b0, input logic [7:0] b1,
                                         input logic [7:0] b2);
    logic [31:0] v;
    v = 32'(addr) << 29;
    v |= 32'(n) << 24;
    if (n > 0) v |= 32'(b0);
    if (n > 1) v |= 32'(b1) << 8;
    if (n > 2) v |= 32'(b2) << 16;
    return v;
  endfunction

  // peripheral sources: present queued bytes, advance on a completed handshake
  task automatic tick();
    @(negedge clk);
    cyc++;
    rst       = rst_req;
    out_ready = ordy_req;
    for (int p = 0; p < NP; p++) begin
      if (hs_prev[p]) src_pos[p]++;
      if (en[p] && src_pos[p] < src_len[p]) begin
        in_valid[p] = 1'b1;
        in_data[p]  = src_mem[p][src_pos[p]];
      end else begin
        in_valid[p] = 1'b0;
        in_data[p]  = 8'h00;
      end
    end
    #1;
    hs_prev = in_valid & in_ready & {NP{~rst}};
    #2;
  endtask

  task automatic load(input int p, input int n, input logic [47:0] bytes);
    for (int i = 0; i < 6; i++) src_mem[p][i] = bytes[i*8 +: 8];
    src_len[p] = n;
    src_pos[p] = 0;
  endtask

  task automatic clear_src();
    en = '0;
    for (int p = 0; p < NP; p++) begin
      src_len[p] = 0;
      src_pos[p] = 0;
    end
  endtask

  task automatic do_reset();
    chk("exp_drained_before_reset", 32'(exp_q.size()), 0);
    rst_req = 1'b1;
    tick();
    tick();
    rst_req = 1'b0;
    tick();
  endtask

  task automatic wait_pkts(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (pkt_cnt < target && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(pkt_cnt), 32'(target));
  endtask

  // compare process: sees exactly what the next rising edge will sample
  logic        hold_prev = 1'b0;
  logic        ov_prev   = 1'b0;
  logic        rst_prev  = 1'b1;
  logic [31:0] held      = '0;

  always begin
    int a, avail;
    logic [7:0] b [3];
    @(negedge clk);
    #2;
    if (rst_prev && !rst) begin
      chk("post_rst_in_ready", 32'(in_ready), 0);
      chk("post_rst_out_valid", 32'(out_valid), 0);
      chk("post_rst_out_packet", out_packet, 0);
    end
    if (rst) begin
      for (int p = 0; p < NP; p++) begin
        acc_wr[p] = 0;
        acc_rd[p] = 0;
      end
      hold_prev = 1'b0;
      ov_prev   = 1'b0;
    end else begin
      chk("in_ready_onehot0", 32'($onehot0(in_ready)), 1);
      if (out_valid) chk("in_ready_during_emit", 32'(in_ready), 0);
      if (hold_prev) begin
        chk("stall_keeps_valid", 32'(out_valid), 1);
        chk("stall_keeps_packet", out_packet, held);
      end
      if (out_valid && !ov_prev) last_rise = cyc;
      for (int p = 0; p < NP; p++) begin
        if (in_valid[p] && in_ready[p] && acc_wr[p] < 64) begin
          acc_mem[p][acc_wr[p]] = in_data[p];
          acc_wr[p]++;
        end
      end
      if (out_valid && out_ready) begin
        a = int'(out_packet[31:29]);
        if (a < NP) begin
          avail = acc_wr[a] - acc_rd[a];
          for (int k = 0; k < 3; k++)
            b[k] = (k < avail) ? acc_mem[a][acc_rd[a] + k] : 8'h00;
          chk("model_pkt", out_packet, mk_pkt(a, avail, b[0], b[1], b[2]));
          acc_rd[a] = acc_wr[a];
        end else begin
          total++;
          bad++;
          $display("FAIL pkt_addr: got %0d expected below %0d", a, NP);
        end
        if (exp_q.size() > 0) begin
          chk("literal_pkt", out_packet, exp_q.pop_front());
        end else begin
          total++;
          bad++;
          $display("FAIL extra_pkt: got %h expected none", out_packet);
        end
        pkt_cnt++;
      end
      hold_prev = out_valid && !out_ready;
      held      = out_packet;
      ov_prev   = out_valid;
    end
    rst_prev = rst;
  end

  initial begin
    int c0, n;
    clear_src();
    repeat (3) tick();
    rst_req = 1'b0;
    tick();
    chk("reset_in_ready", 32'(in_ready), 0);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_out_packet", out_packet, 0);

    // peripheral 1 three-byte burst
    ordy_req = 1'b1;
    load(1, 3, 48'h0000_00C3_B2A1);
    en = 4'b0010;
    c0 = cyc + 1;
    exp_q.push_back(32'h23C3_B2A1);
    wait_pkts(1, 30, "burst_pkt_count");
    chk("burst_latency", 32'(last_rise - c0), 4);
    clear_src();

    // single byte then silence: flushed by timeout
    load(0, 1, 48'h0000_0000_0055);
    en = 4'b0001;
    c0 = cyc + 1;
    exp_q.push_back(32'h0100_0055);
    wait_pkts(2, 60, "timeout_pkt_count");
    chk("timeout_latency", 32'(last_rise - c0), 32'(TO + 2));
    clear_src();

    // two continuous requesters alternate starting at address 0
    do_reset();
    load(0, 6, 48'h1514_1312_1110);
    load(1, 6, 48'h2524_2322_2120);
    en = 4'b0011;
    exp_q.push_back(32'h0312_1110);
    exp_q.push_back(32'h2322_2120);
    exp_q.push_back(32'h0315_1413);
    exp_q.push_back(32'h2325_2423);
    wait_pkts(6, 80, "alternate_pkt_count");
    clear_src();

    // out_ready held low in EMIT
    do_reset();
    ordy_req = 1'b0;
    load(2, 3, 48'h0000_0003_0201);
    load(3, 1, 48'h0000_0000_0077);
    en = 4'b1100;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk("stall_reached_emit", 32'(out_valid), 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("stall_in_ready", 32'(in_ready), 0);
      chk("stall_out_valid", 32'(out_valid), 1);
      chk("stall_out_packet", out_packet, 32'h4303_0201);
    end
    exp_q.push_back(32'h4303_0201);
    exp_q.push_back(32'h6100_0077);
    ordy_req = 1'b1;
    wait_pkts(8, 60, "stall_pkt_count");
    clear_src();

    // reset after two bytes accepted
    do_reset();
    load(1, 5, 48'h0035_3433_3231);
    en = 4'b0010;
    tick();
    tick();
    tick();
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    tick();
    chk("midrst_in_ready", 32'(in_ready), 0);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_out_packet", out_packet, 0);
    chk("midrst_no_pkt", 32'(pkt_cnt), 8);
    exp_q.push_back(32'h2335_3433);
    wait_pkts(9, 40, "midrst_pkt_count");
    clear_src();

    // grantee drops in_valid before any byte: no packet, pointer advances
    do_reset();
    load(0, 3, 48'h0000_0097_9899);
    en = 4'b0001;
    tick();
    en = 4'b0000;
    repeat (TO + 4) tick();
    chk("drop_no_pkt", 32'(pkt_cnt), 9);
    chk("drop_back_idle", 32'(in_ready), 0);
    load(1, 3, 48'h0000_0043_4241);
    en = 4'b0011;
    exp_q.push_back(32'h2343_4241);
    exp_q.push_back(32'h0397_9899);
    wait_pkts(11, 60, "drop_pkt_count");
    clear_src();

    repeat (3) tick();
    chk("exp_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lycan_packet_packer.md
# lycan_packet_packer

Peripheral-to-host packet packer. Collects byte streams from all `num_peripherals` peripheral outputs, arbitrates round-robin, and packs up to three bytes from one peripheral into a 32-bit USB packet tagged with the source peripheral address. It is the upstream (device-to-host) counterpart of the host-to-peripheral packet parser/router and sits between the peripheral array and the USB TX FIFO.

## Interface

Parameters
- `NUM_PERIPH`, default `lycan_globals::num_peripherals`: number of byte-stream inputs.
- `TIMEOUT_CYCLES`, default 16: idle cycles in COLLECT before a partial packet is flushed; legal range 1..255.

Ports
- `clk` input 1: sole clock.
- `rst` input 1: synchronous, active-high reset.
- `in_data` input `[NUM_PERIPH][7:0]`: byte from each peripheral.
- `in_valid` input `[NUM_PERIPH]`: byte available.
- `in_ready` output `[NUM_PERIPH]`: byte accepted when `in_valid && in_ready`.
- `out_packet` output `[usb_packet_width-1:0]`: formatted packet.
- `out_valid` output 1: packet available.
- `out_ready` input 1: USB TX FIFO accepts packet.

## Operation

Packet format (data packet):
- [31:29] peripheral address (`periph_address_width`).
- [28] config flag, always 0 from this block.
- [27:26] reserved, 0.
- [25:24] valid byte count, 1..3; never 0.
- [23:0] bytes; first accepted byte in [7:0], second [15:8], third [23:16]; unused bytes 0.

States:
- IDLE: all `in_ready` low, `out_valid` low. If any `in_valid` is high, grant the first requester at or after the round-robin pointer (wrapping past `NUM_PERIPH-1` to 0). Latch the grant index, clear the byte count and timeout counter, then go to COLLECT. No byte is accepted in IDLE.
- COLLECT: `in_ready` is high only for the granted index. Each accepted byte is stored at the byte count position, the count increments, and the timeout counter clears.
  - When the third byte is accepted, go to EMIT.
  - On a cycle with no accept, the timeout counter increments. When it reaches `TIMEOUT_CYCLES` with count ≥1, go to EMIT.
  - If the count is still 0 at timeout (requester dropped `in_valid`), return to IDLE with no packet and advance the pointer.
- EMIT: `in_ready` all low. `out_valid` is high and `out_packet` is stable until `out_ready`. On handshake, set the pointer to grant+1 (mod `NUM_PERIPH`) and return to IDLE.

Boundary rules:
- Simultaneous requests are resolved strictly by the pointer; the grantee loses priority after its packet.
- `out_ready` held low stalls indefinitely with no data loss. Peripherals simply see `in_ready` low.
- `in_valid` from non-granted peripherals is ignored and does not affect the timeout.
- Reset mid-packet discards any partial or pending packet; no byte is lost from a peripheral whose handshake had not completed.

## Timing

- Reset values: `in_ready`=0, `out_valid`=0, `out_packet`=0, state IDLE, pointer 0, counters 0.
- All outputs are registered or decoded only from registered state. There is no combinational path from `out_ready` or `in_valid` to any output.
- Back-to-back three-byte burst: `in_valid` first seen at cycle 0 (IDLE), bytes accepted at cycles 1, 2, 3, `out_valid` from cycle 4. Minimum 5 cycles per packet including the EMIT handshake cycle, and 1 IDLE cycle between packets.
- Timeout flush: `out_valid` rises `TIMEOUT_CYCLES`+1 cycles after the last accepted byte.

## Structure

- Add to `lycan_globals`:
  - packet field position constants (address MSB/LSB, config bit, count field);
  - `localparam int bytes_per_packet = 3`;
  - a packed struct `usb_data_packet_t` matching the format above.
- State enum `packer_state_t` (IDLE, COLLECT, EMIT) is local to the module.
- Sub-module `lycan_rr_arbiter` (request vector + pointer in, one-hot grant + index out, combinational), which the host-side router can reuse.

## Test plan

- Peripheral 1 sends 0xA1, 0xB2, 0xC3 back-to-back with `out_ready`=1 -> one packet 0x2300_0000|(3<<24)|0xC3B2A1 = 0x23C3B2A1 at cycle 4.
- Peripheral 0 sends a single byte 0x55 then drops `in_valid` -> after `TIMEOUT_CYCLES`+1 cycles, packet 0x01000055.
- Both peripherals hold `in_valid` continuously with 3-byte bursts -> packets alternate address 0, 1, 0, 1 starting from address 0 after reset.
- `out_ready` held low 20 cycles in EMIT -> `out_packet` is stable and all `in_ready` stay low. Releasing `out_ready` gives a single handshake with no duplicate packet.
- Assert `rst` for 1 cycle after 2 bytes are accepted -> no packet emitted, all outputs 0 the next cycle, and a subsequent 3-byte burst packs correctly.
- Grantee drops `in_valid` before sending any byte -> IDLE after timeout, no packet, and the pointer advances.
